// File: rtl/clock_edge_receiver.sv
// rtl/clock_edge_receiver.sv - samples an asynchronous slow clock in the clk domain.
// It produces rise/fall enables, period and high-time measurements, and a stall flag.
module clock_edge_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 24,
    parameter int TIMEOUT     = 8000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_in,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 stalled
);

    localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] LP_THRESH  = CNT_WIDTH'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_armed;
    logic                   r_rise_tick;
    logic                   r_fall_tick;
    logic [CNT_WIDTH-1:0]   r_period;
    logic [CNT_WIDTH-1:0]   r_high_time;
    logic                   r_period_valid;
    logic                   r_stalled;

    logic w_last;
    logic w_rise;
    logic w_fall;
    logic w_stall_hit;

    assign w_last      = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_last & ~r_prev;
    assign w_fall      = ~w_last & r_prev;
    // A rise landing on the threshold cycle wins over the stall.
    assign w_stall_hit = (r_cnt == LP_THRESH) && !w_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync         <= '0;
            r_prev         <= 1'b0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_rise_tick    <= 1'b0;
            r_fall_tick    <= 1'b0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], clk_in};
            r_prev      <= w_last;
            r_rise_tick <= w_rise;
            r_fall_tick <= w_fall;

            if (w_rise) begin
                r_cnt <= CNT_WIDTH'(1);
            end else if (r_cnt != LP_TIMEOUT) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end

            if (w_rise) begin
                r_armed   <= 1'b1;
                r_stalled <= 1'b0;
                // Only a rise following an armed, unstalled rise is a real period.
                if (r_armed && !r_stalled) begin
                    r_period       <= r_cnt;
                    r_period_valid <= 1'b1;
                end else begin
                    r_period_valid <= 1'b0;
                end
            end else if (w_stall_hit) begin
                r_stalled      <= 1'b1;
                r_period_valid <= 1'b0;
                r_armed        <= 1'b0;
            end

            if (w_fall && r_armed) begin
                r_high_time <= r_cnt;
            end
        end
    end

    assign rise_tick    = r_rise_tick;
    assign fall_tick    = r_fall_tick;
    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign stalled      = r_stalled;

endmodule
